// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes F<a><b>/D<t><u> line commands into pwm_gen settings and answers K/E.
// Define QUERY_CMD_EN to add the "?" command, which streams back the current settings.
module uart_cmd_parser #(
  parameter logic [7:0] ACK_CHAR = 8'h4B,
  parameter logic [7:0] NAK_CHAR = 8'h45
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] pow2,
  output logic [1:0] pow5,
  output logic [6:0] duty_cycle,
  output logic       cfg_update,
  output logic       resp_drop
);
`ifdef QUERY_CMD_EN
  typedef enum logic [3:0] {IDLE, F1, F2, F3, D1, D2, D3, ERR, Q1} state_t;
`else
  typedef enum logic [2:0] {IDLE, F1, F2, F3, D1, D2, D3, ERR} state_t;
`endif
  state_t state_q, state_d;
  logic [3:0] dig0_q, dig0_d, dig1_q, dig1_d, digit;
  logic [1:0] pow2_q, pow2_d, pow5_q, pow5_d;
  logic [6:0] duty_q, duty_d;
  logic [7:0] tx_data_q, tx_data_d, resp_byte;
  logic tx_valid_q, tx_valid_d, cfg_update_q, cfg_update_d, resp_drop_q, resp_drop_d;
  logic is_term, is_f, is_d, dig4, dig10, resp_due, tx_busy;
`ifdef QUERY_CMD_EN
  logic [2:0] q_left_q, q_left_d;
  logic [15:0] snap_q, snap_d;
  logic [3:0] dt_q, dt_d, du_q, du_d;
  logic q_start;
`endif
  always_comb begin
    digit = rx_data[3:0];
    is_term = rx_data == 8'h0D || rx_data == 8'h0A;
    is_f = rx_data == 8'h46 || rx_data == 8'h66;
    is_d = rx_data == 8'h44 || rx_data == 8'h64;
    dig4 = rx_data >= 8'h30 && rx_data <= 8'h33;
    dig10 = rx_data >= 8'h30 && rx_data <= 8'h39;
    state_d = state_q;
    dig0_d = dig0_q;
    dig1_d = dig1_q;
    pow2_d = pow2_q;
    pow5_d = pow5_q;
    duty_d = duty_q;
    cfg_update_d = 1'b0;
    resp_drop_d = 1'b0;
    resp_due = 1'b0;
    resp_byte = NAK_CHAR;
    tx_valid_d = tx_valid_q & ~tx_ready;
    tx_data_d = tx_data_q;
    tx_busy = tx_valid_q & ~tx_ready;
`ifdef QUERY_CMD_EN
    q_left_d = q_left_q;
    snap_d = snap_q;
    dt_d = dt_q;
    du_d = du_q;
    q_start = 1'b0;
    // While streaming, each accepted byte is immediately replaced by the next one
    if (tx_valid_q && tx_ready && q_left_q != 3'd0) begin
      tx_valid_d = 1'b1;
      tx_data_d = q_left_q == 3'd1 ? 8'h0A : {4'h3, q_left_q == 3'd4 ? snap_q[11:8] :
                                                   q_left_q == 3'd3 ? snap_q[7:4] : snap_q[3:0]};
      q_left_d = q_left_q - 3'd1;
    end
    tx_busy = tx_busy | (q_left_q != 3'd0);
`endif
    if (rx_valid)
      case (state_q)
        IDLE: begin
          state_d = is_f ? F1 : is_d ? D1 : is_term ? IDLE : ERR;
`ifdef QUERY_CMD_EN
          if (rx_data == 8'h3F) state_d = Q1;
`endif
        end
        F1: begin
          dig0_d = digit;
          state_d = dig4 ? F2 : is_term ? IDLE : ERR;
          resp_due = is_term;
        end
        F2: begin
          dig1_d = digit;
          state_d = dig4 ? F3 : is_term ? IDLE : ERR;
          resp_due = is_term;
        end
        D1: begin
          dig0_d = digit;
          state_d = dig10 ? D2 : is_term ? IDLE : ERR;
          resp_due = is_term;
        end
        D2: begin
          dig1_d = digit;
          state_d = dig10 ? D3 : is_term ? IDLE : ERR;
          resp_due = is_term;
        end
        F3: begin
          state_d = is_term ? IDLE : ERR;
          if (is_term) begin
            pow2_d = dig0_q[1:0];
            pow5_d = dig1_q[1:0];
            cfg_update_d = 1'b1;
            resp_due = 1'b1;
            resp_byte = ACK_CHAR;
          end
        end
        D3: begin
          state_d = is_term ? IDLE : ERR;
          if (is_term) begin
            duty_d = 7'(dig0_q) * 7'd10 + 7'(dig1_q);
`ifdef QUERY_CMD_EN
            dt_d = dig0_q;
            du_d = dig1_q;
`endif
            cfg_update_d = 1'b1;
            resp_due = 1'b1;
            resp_byte = ACK_CHAR;
          end
        end
        ERR: begin
          state_d = is_term ? IDLE : ERR;
          resp_due = is_term;
        end
`ifdef QUERY_CMD_EN
        Q1: begin
          state_d = is_term ? IDLE : ERR;
          q_start = is_term;
        end
`endif
        default: state_d = IDLE;
      endcase
    if (resp_due) begin
      if (tx_busy) resp_drop_d = 1'b1;
      else begin
        tx_valid_d = 1'b1;
        tx_data_d = resp_byte;
      end
    end
`ifdef QUERY_CMD_EN
    if (q_start) begin
      if (tx_busy) resp_drop_d = 1'b1;
      else begin
        tx_valid_d = 1'b1;
        tx_data_d = {6'h0C, pow2_q};
        snap_d = {2'b00, pow2_q, 2'b00, pow5_q, dt_q, du_q};
        q_left_d = 3'd4;
      end
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      dig0_q <= 4'd0;
      dig1_q <= 4'd0;
      pow2_q <= 2'd0;
      pow5_q <= 2'd0;
      duty_q <= 7'd0;
      tx_data_q <= 8'h00;
      tx_valid_q <= 1'b0;
      cfg_update_q <= 1'b0;
      resp_drop_q <= 1'b0;
`ifdef QUERY_CMD_EN
      q_left_q <= 3'd0;
      snap_q <= 16'd0;
      dt_q <= 4'd0;
      du_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      dig0_q <= dig0_d;
      dig1_q <= dig1_d;
      pow2_q <= pow2_d;
      pow5_q <= pow5_d;
      duty_q <= duty_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cfg_update_q <= cfg_update_d;
      resp_drop_q <= resp_drop_d;
`ifdef QUERY_CMD_EN
      q_left_q <= q_left_d;
      snap_q <= snap_d;
      dt_q <= dt_d;
      du_q <= du_d;
`endif
    end
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign pow2 = pow2_q;
  assign pow5 = pow5_q;
  assign duty_cycle = duty_q;
  assign cfg_update = cfg_update_q;
  assign resp_drop = resp_drop_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed plus random command lines checked against a line-level model.
module tb_uart_cmd_parser;
  logic clk = 1'b0, rst_n = 1'b1, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic tx_valid, cfg_update, resp_drop;
  logic [1:0] pow2, pow5;
  logic [6:0] duty_cycle;
  int tests = 0, fails = 0, rdy_mode = 1, cfg_cnt = 0, drop_cnt = 0, vcnt = 0;
  logic [7:0] got[$];
  logic [7:0] line_q[$];
  logic [7:0] sq[$];
  logic m_valid, e_cfg, e_drop;
  logic [7:0] m_data;
  logic [1:0] m_pow2, m_pow5;
  logic [6:0] m_duty;

  uart_cmd_parser dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pow2(pow2), .pow5(pow5), .duty_cycle(duty_cycle),
    .cfg_update(cfg_update), .resp_drop(resp_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic isdig(input logic [7:0] c, input int mx);
    return int'(c) >= 48 && int'(c) <= 48 + mx;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 8'h00; m_pow2 = 0; m_pow5 = 0; m_duty = 0;
    e_cfg = 0; e_drop = 0;
    sq.delete(); line_q.delete();
  endtask

  // Whole-line view: a non-empty line is either a legal command (ACK/query) or it is NAKed
  task automatic model_edge(input logic v, input logic [7:0] b, input logic rdy);
    logic busy, due, qry;
    logic [7:0] rb;
    int n;
    e_cfg = 0; e_drop = 0; due = 0; qry = 0; rb = 8'h45;
    busy = (m_valid && !rdy) || sq.size() != 0;
    if (m_valid && rdy) begin
      if (sq.size() != 0) m_data = sq.pop_front();
      else m_valid = 0;
    end
    if (v) begin
      if (b == 8'h0D || b == 8'h0A) begin
        n = line_q.size();
        if (n == 3 && (line_q[0] | 8'h20) == 8'h66 && isdig(line_q[1], 3) && isdig(line_q[2], 3)) begin
          m_pow2 = 2'(int'(line_q[1]) - 48);
          m_pow5 = 2'(int'(line_q[2]) - 48);
          e_cfg = 1; due = 1; rb = 8'h4B;
        end else if (n == 3 && (line_q[0] | 8'h20) == 8'h64 && isdig(line_q[1], 9) && isdig(line_q[2], 9)) begin
          m_duty = 7'(10 * (int'(line_q[1]) - 48) + int'(line_q[2]) - 48);
          e_cfg = 1; due = 1; rb = 8'h4B;
`ifdef QUERY_CMD_EN
        end else if (n == 1 && line_q[0] == 8'h3F) begin
          qry = 1;
`endif
        end else if (n != 0) due = 1;
        line_q.delete();
      end else line_q.push_back(b);
    end
    if (due || qry) begin
      if (busy) e_drop = 1;
      else if (due) begin
        m_valid = 1; m_data = rb;
      end else begin
        m_valid = 1; m_data = 8'(48 + int'(m_pow2));
        sq.push_back(8'(48 + int'(m_pow5)));
        sq.push_back(8'(48 + int'(m_duty) / 10));
        sq.push_back(8'(48 + int'(m_duty) % 10));
        sq.push_back(8'h0A);
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    logic rdy;
    rdy = (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
    rx_valid = v;
    rx_data = v ? b : 8'($urandom);
    tx_ready = rdy;
    if (tx_valid && rdy) got.push_back(tx_data);
    @(posedge clk);
    model_edge(v, b, rdy);
    @(negedge clk);
    cfg_cnt += int'(cfg_update);
    drop_cnt += int'(resp_drop);
    vcnt += int'(tx_valid);
    chk("tx_valid", tx_valid, m_valid);
    if (m_valid) chk("tx_data", tx_data, m_data);
    chk("resp_drop", resp_drop, e_drop);
    chk("cfg_update", cfg_update, e_cfg);
    chk("pow2", pow2, m_pow2);
    chk("pow5", pow5, m_pow5);
    chk("duty_cycle", duty_cycle, m_duty);
  endtask

  task automatic clr();
    got.delete(); cfg_cnt = 0; drop_cnt = 0; vcnt = 0;
  endtask

  task automatic send(input string s, input logic [7:0] t);
    for (int i = 0; i < s.len(); i++) step(1, s[i]);
    step(1, t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; rx_valid = 0;
    #2;
    model_reset();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_pow2", pow2, 0);
    chk("rst_pow5", pow5, 0);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_cfg_update", cfg_update, 0);
    chk("rst_resp_drop", resp_drop, 0);
    @(negedge clk);
    rst_n = 1;
    clr();
  endtask

  task automatic rand_line();
    logic [7:0] q[$];
    logic [7:0] t;
    int k;
    t = $urandom_range(0, 1) ? 8'h0D : 8'h0A;
    k = $urandom_range(0, 7);
    case (k)
      0: q = '{$urandom_range(0, 1) ? 8'h46 : 8'h66, 8'(48 + $urandom_range(0, 3)), 8'(48 + $urandom_range(0, 3))};
      1: q = '{$urandom_range(0, 1) ? 8'h44 : 8'h64, 8'(48 + $urandom_range(0, 9)), 8'(48 + $urandom_range(0, 9))};
      2: q = '{$urandom_range(0, 1) ? 8'h46 : 8'h44, 8'(48 + $urandom_range(0, 9)), 8'(47 + $urandom_range(0, 12))};
      3: q = '{};
      4: q = '{8'h3F};
      5: for (int i = 0; i < int'($urandom_range(0, 4)); i++) q.push_back(8'($urandom_range(32, 126)));
      6: q = '{8'h66, 8'(48 + $urandom_range(0, 3))};
      default: for (int i = 0; i < int'($urandom_range(1, 5)); i++) q.push_back(8'($urandom));
    endcase
    q.push_back(t);
    foreach (q[i]) begin
      step(1, q[i]);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    rdy_mode = 1;
    send("F23", 8'h0D);
    idle(3);
    chk("f23_pow2", pow2, 2);
    chk("f23_pow5", pow5, 3);
    chk("f23_duty", duty_cycle, 0);
    chk("f23_cfg_pulses", cfg_cnt, 1);
    chk("f23_valid_cycles", vcnt, 1);
    chk("f23_resp_count", got.size(), 1);
    if (got.size() == 1) chk("f23_ack", got[0], 8'h4B);
    clr();
    send("d75", 8'h0A);
    step(1, 8'h0A);
    idle(3);
    chk("d75_duty", duty_cycle, 75);
    chk("d75_pow2", pow2, 2);
    chk("d75_resp_count", got.size(), 1);
    if (got.size() == 1) chk("d75_ack", got[0], 8'h4B);
    clr();
    send("F4x1", 8'h0D);
    send("D7", 8'h0D);
    idle(3);
    chk("bad_resp_count", got.size(), 2);
    foreach (got[i]) chk("bad_nak", got[i], 8'h45);
    chk("bad_cfg_pulses", cfg_cnt, 0);
    chk("bad_duty", duty_cycle, 75);
    clr();
    rdy_mode = 0;
    send("D10", 8'h0D);
    send("D20", 8'h0D);
    idle(2);
    chk("busy_duty", duty_cycle, 20);
    chk("busy_tx_data", tx_data, 8'h4B);
    chk("busy_tx_valid", tx_valid, 1);
    chk("busy_drops", drop_cnt, 1);
    rdy_mode = 1;
    idle(3);
    chk("busy_accepted", got.size(), 1);
    chk("busy_valid_low", tx_valid, 0);
    step(1, 8'h46);
    step(1, 8'h31);
    do_reset();
    send("3", 8'h0D);
    idle(3);
    chk("rst_mid_resp_count", got.size(), 1);
    if (got.size() == 1) chk("rst_mid_nak", got[0], 8'h45);
    chk("rst_mid_pow2", pow2, 0);
    chk("rst_mid_pow5", pow5, 0);
    send("F12", 8'h0D);
    send("D05", 8'h0D);
    idle(3);
    clr();
    send("?", 8'h0D);
    idle(8);
`ifdef QUERY_CMD_EN
    chk("query_count", got.size(), 5);
    if (got.size() == 5) begin
      chk("query_b0", got[0], 8'h31);
      chk("query_b1", got[1], 8'h32);
      chk("query_b2", got[2], 8'h30);
      chk("query_b3", got[3], 8'h35);
      chk("query_b4", got[4], 8'h0A);
    end
`else
    chk("query_count", got.size(), 1);
    if (got.size() == 1) chk("query_nak", got[0], 8'h45);
`endif
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      rand_line();
      if (i % 100 == 99) do_reset();
    end
    rdy_mode = 1;
    idle(10);
    chk("final_idle", tx_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
